// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage MIPS core: resolves load-use, redirect,
// memory-wait and halt hazards and drives per-latch enable/flush plus pcEN.
module hazard_controller #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             MMdREN,
  input  logic             MMdWEN,
  input  logic             MMhalt,
  input  logic             EXmemRead,
  input  logic [REG_W-1:0] EXrd,
  input  logic [REG_W-1:0] IDrs,
  input  logic [REG_W-1:0] IDrt,
  input  logic             EXpcSrc,
  output logic             pcEN,
  output logic             IFIDen,
  output logic             IFIDflush,
  output logic             IDEXen,
  output logic             IDEXflush,
  output logic             EXMMen,
  output logic             MMWBen,
  output logic             halt,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             memreq;
  logic             luse;
  logic             apply_rules;

  assign memreq = MMdREN | MMdWEN;
  assign luse   = EXmemRead && (EXrd != '0) && ((EXrd == IDrs) || (EXrd == IDrt));

  always_comb begin
    state_d     = state_q;
    apply_rules = 1'b0;
    pcEN        = 1'b0;
    IFIDen      = 1'b0;
    IFIDflush   = 1'b0;
    IDEXen      = 1'b0;
    IDEXflush   = 1'b0;
    EXMMen      = 1'b0;
    MMWBen      = 1'b0;

    case (state_q)
      RUN: begin
        if (memreq && !dhit) begin
          state_d = DWAIT;
        end else begin
          apply_rules = 1'b1;
        end
      end
      DWAIT: begin
        if (dhit) begin
          state_d     = RUN;
          apply_rules = 1'b1;
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase

    // Rules 2-6 are shared by RUN and the completing cycle of DWAIT.
    if (apply_rules) begin
      if (MMhalt) begin
        MMWBen  = 1'b1;
        state_d = HALTED;
      end else if (EXpcSrc) begin
        pcEN      = 1'b1;
        IFIDen    = 1'b1;
        IFIDflush = 1'b1;
        IDEXen    = 1'b1;
        IDEXflush = 1'b1;
        EXMMen    = 1'b1;
        MMWBen    = 1'b1;
      end else if (luse) begin
        IDEXen    = 1'b1;
        IDEXflush = 1'b1;
        EXMMen    = 1'b1;
        MMWBen    = 1'b1;
      end else if (!ihit) begin
        IFIDen    = 1'b1;
        IFIDflush = 1'b1;
        IDEXen    = 1'b1;
        EXMMen    = 1'b1;
        MMWBen    = 1'b1;
      end else begin
        pcEN   = 1'b1;
        IFIDen = 1'b1;
        IDEXen = 1'b1;
        EXMMen = 1'b1;
        MMWBen = 1'b1;
      end
    end

    if (!nRST) begin
      pcEN      = 1'b0;
      IFIDen    = 1'b0;
      IFIDflush = 1'b0;
      IDEXen    = 1'b0;
      IDEXflush = 1'b0;
      EXMMen    = 1'b0;
      MMWBen    = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pcEN && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halt        = (state_q == HALTED);
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized
// traffic compared against a rule-level behavioural model.
module tb_hazard_controller;

  localparam logic [6:0] V_ALL   = 7'b1101011;
  localparam logic [6:0] V_REDIR = 7'b1111111;
  localparam logic [6:0] V_LUSE  = 7'b0001111;
  localparam logic [6:0] V_NOIH  = 7'b0111011;
  localparam logic [6:0] V_HALT  = 7'b0000001;
  localparam logic [6:0] V_NONE  = 7'b0000000;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b1, dhit = 1'b0, MMdREN = 1'b0, MMdWEN = 1'b0, MMhalt = 1'b0;
  logic       EXmemRead = 1'b0, EXpcSrc = 1'b0;
  logic [4:0] EXrd = '0, IDrs = '0, IDrt = '0;

  logic        pcEN, IFIDen, IFIDflush, IDEXen, IDEXflush, EXMMen, MMWBen, halt;
  logic [15:0] stall_count;
  logic        s_pcEN, s_IFIDen, s_IFIDflush, s_IDEXen, s_IDEXflush, s_EXMMen, s_MMWBen, s_halt;
  logic [3:0]  s_stall_count;

  int total = 0;
  int bad = 0;

  bit m_wait = 0;
  bit m_halt = 0;
  int m_cnt = 0;

  wire [6:0] en_vec   = {pcEN, IFIDen, IFIDflush, IDEXen, IDEXflush, EXMMen, MMWBen};
  wire [6:0] s_en_vec = {s_pcEN, s_IFIDen, s_IFIDflush, s_IDEXen, s_IDEXflush, s_EXMMen, s_MMWBen};

  hazard_controller #(.REG_W(5), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .MMdREN(MMdREN), .MMdWEN(MMdWEN),
    .MMhalt(MMhalt), .EXmemRead(EXmemRead), .EXrd(EXrd), .IDrs(IDrs), .IDrt(IDrt),
    .EXpcSrc(EXpcSrc), .pcEN(pcEN), .IFIDen(IFIDen), .IFIDflush(IFIDflush),
    .IDEXen(IDEXen), .IDEXflush(IDEXflush), .EXMMen(EXMMen), .MMWBen(MMWBen),
    .halt(halt), .stall_count(stall_count)
  );

  hazard_controller #(.REG_W(5), .CNT_W(4)) dut_small (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .MMdREN(MMdREN), .MMdWEN(MMdWEN),
    .MMhalt(MMhalt), .EXmemRead(EXmemRead), .EXrd(EXrd), .IDrs(IDrs), .IDrt(IDrt),
    .EXpcSrc(EXpcSrc), .pcEN(s_pcEN), .IFIDen(s_IFIDen), .IFIDflush(s_IFIDflush),
    .IDEXen(s_IDEXen), .IDEXflush(s_IDEXflush), .EXMMen(s_EXMMen), .MMWBen(s_MMWBen),
    .halt(s_halt), .stall_count(s_stall_count)
  );

  always #5 CLK = ~CLK;

  // Expected latch controls, written straight from the priority list.
  function automatic logic [6:0] model_out();
    bit memreq = MMdREN | MMdWEN;
    bit luse = EXmemRead && (EXrd != 0) && ((EXrd == IDrs) || (EXrd == IDrt));
    if (!nRST) return V_NONE;
    if (m_halt) return V_NONE;
    if (!m_wait && memreq && !dhit) return V_NONE;
    if (m_wait && !dhit) return V_NONE;
    if (MMhalt) return V_HALT;
    if (EXpcSrc) return V_REDIR;
    if (luse) return V_LUSE;
    if (!ihit) return V_NOIH;
    return V_ALL;
  endfunction

  function automatic int cap(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0; MMdREN = 1'b0; MMdWEN = 1'b0; MMhalt = 1'b0;
    EXmemRead = 1'b0; EXpcSrc = 1'b0; EXrd = '0; IDrs = '0; IDrt = '0;
  endtask

  // Advance one clock, updating the model from the pre-edge inputs.
  task automatic tick();
    logic [6:0] e;
    bit memreq;
    e = model_out();
    memreq = MMdREN | MMdWEN;
    if (nRST) begin
      if (!e[6]) m_cnt++;
      if (m_halt) begin
      end else if (!m_wait && memreq && !dhit) begin
        m_wait = 1;
      end else if (m_wait && !dhit) begin
      end else begin
        m_wait = 0;
        if (MMhalt) m_halt = 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    set_idle();
    m_wait = 0; m_halt = 0; m_cnt = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nRST = 1'b1;
    ihit = 1'b0; EXpcSrc = 1'b1;
    #1;
    nRST = 1'b0;
    #1;
    total++;
    if (en_vec !== V_NONE) begin bad++; $display("[TB] FAIL reset_en got=%b want=%b", en_vec, V_NONE); end
    total++;
    if (halt !== 1'b0) begin bad++; $display("[TB] FAIL reset_halt got=%b want=0", halt); end
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", stall_count); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    EXmemRead = 1'b1; EXrd = 5'd5; IDrs = 5'd5; IDrt = 5'd9;
    #1;
    total++;
    if (en_vec !== V_LUSE) begin bad++; $display("[TB] FAIL luse_bubble got=%b want=%b", en_vec, V_LUSE); end
    tick();
    EXmemRead = 1'b0;
    #1;
    total++;
    if (en_vec !== V_ALL) begin bad++; $display("[TB] FAIL luse_release got=%b want=%b", en_vec, V_ALL); end
    total++;
    if (stall_count !== 16'd1) begin bad++; $display("[TB] FAIL luse_cnt got=%0d want=1", stall_count); end
    EXmemRead = 1'b1; EXrd = 5'd7; IDrs = 5'd3; IDrt = 5'd7;
    #1;
    total++;
    if (en_vec !== V_LUSE) begin bad++; $display("[TB] FAIL luse_rt got=%b want=%b", en_vec, V_LUSE); end
    tick();
  endtask

  task automatic test_r0_exempt();
    do_reset();
    EXmemRead = 1'b1; EXrd = 5'd0; IDrs = 5'd0; IDrt = 5'd0;
    #1;
    total++;
    if (en_vec !== V_ALL) begin bad++; $display("[TB] FAIL r0_exempt got=%b want=%b", en_vec, V_ALL); end
    tick();
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("[TB] FAIL r0_cnt got=%0d want=0", stall_count); end
  endtask

  task automatic test_dwait();
    do_reset();
    MMdREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (en_vec !== V_NONE) begin bad++; $display("[TB] FAIL dwait_hold[%0d] got=%b want=%b", i, en_vec, V_NONE); end
      tick();
    end
    dhit = 1'b1;
    #1;
    total++;
    if (en_vec !== V_ALL) begin bad++; $display("[TB] FAIL dwait_done got=%b want=%b", en_vec, V_ALL); end
    tick();
    MMdREN = 1'b0; dhit = 1'b0;
    #1;
    total++;
    if (en_vec !== V_ALL) begin bad++; $display("[TB] FAIL dwait_run got=%b want=%b", en_vec, V_ALL); end
    total++;
    if (stall_count !== 16'd3) begin bad++; $display("[TB] FAIL dwait_cnt got=%0d want=3", stall_count); end
    MMdWEN = 1'b1; dhit = 1'b1;
    #1;
    total++;
    if (en_vec !== V_ALL) begin bad++; $display("[TB] FAIL zero_wait got=%b want=%b", en_vec, V_ALL); end
    tick();
    MMdWEN = 1'b0; dhit = 1'b0;
    #1;
    total++;
    if (en_vec !== V_ALL) begin bad++; $display("[TB] FAIL zero_wait_next got=%b want=%b", en_vec, V_ALL); end
    MMdREN = 1'b1;
    tick();
    #1;
    nRST = 1'b0;
    #1;
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("[TB] FAIL dwait_reset_cnt got=%0d want=0", stall_count); end
    m_wait = 0; m_cnt = 0;
    MMdREN = 1'b0;
    nRST = 1'b1;
    #1;
    total++;
    if (en_vec !== V_ALL) begin bad++; $display("[TB] FAIL dwait_reset_run got=%b want=%b", en_vec, V_ALL); end
  endtask

  task automatic test_redirect();
    do_reset();
    EXpcSrc = 1'b1; EXmemRead = 1'b1; EXrd = 5'd5; IDrs = 5'd5; ihit = 1'b0;
    #1;
    total++;
    if (en_vec !== V_REDIR) begin bad++; $display("[TB] FAIL redirect got=%b want=%b", en_vec, V_REDIR); end
    tick();
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("[TB] FAIL redirect_cnt got=%0d want=0", stall_count); end
    EXpcSrc = 1'b0; EXmemRead = 1'b0;
    #1;
    total++;
    if (en_vec !== V_NOIH) begin bad++; $display("[TB] FAIL imiss got=%b want=%b", en_vec, V_NOIH); end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    MMhalt = 1'b1;
    #1;
    total++;
    if (en_vec !== V_HALT) begin bad++; $display("[TB] FAIL halt_retire got=%b want=%b", en_vec, V_HALT); end
    total++;
    if (halt !== 1'b0) begin bad++; $display("[TB] FAIL halt_early got=%b want=0", halt); end
    tick();
    MMhalt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; EXpcSrc = ~i[0]; dhit = i[1];
      #1;
      total++;
      if (en_vec !== V_NONE || halt !== 1'b1) begin
        bad++; $display("[TB] FAIL halted[%0d] got=%b/%b want=%b/1", i, en_vec, halt, V_NONE);
      end
      tick();
    end
    total++;
    if (stall_count !== 16'd11) begin bad++; $display("[TB] FAIL halt_cnt got=%0d want=11", stall_count); end
    nRST = 1'b0;
    #1;
    total++;
    if (halt !== 1'b0 || stall_count !== 16'd0) begin
      bad++; $display("[TB] FAIL halt_exit got=%b/%0d want=0/0", halt, stall_count);
    end
    do_reset();
  endtask

  task automatic test_saturate();
    do_reset();
    ihit = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (s_stall_count !== 4'd14) begin bad++; $display("[TB] FAIL sat_pre got=%0d want=14", s_stall_count); end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (s_stall_count !== 4'd15) begin bad++; $display("[TB] FAIL sat_hold got=%0d want=15", s_stall_count); end
    total++;
    if (stall_count !== 16'd19) begin bad++; $display("[TB] FAIL sat_wide got=%0d want=19", stall_count); end
  endtask

  task automatic test_random();
    logic [6:0] e;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) begin
        nRST = 1'b0;
        #1;
        total++;
        if (en_vec !== V_NONE || halt !== 1'b0 || stall_count !== 16'd0) begin
          bad++; $display("[TB] FAIL rand_reset[%0d] got=%b/%b/%0d", n, en_vec, halt, stall_count);
        end
        m_wait = 0; m_halt = 0; m_cnt = 0;
        nRST = 1'b1;
      end
      ihit      = ($urandom_range(0, 3) != 0);
      dhit      = $urandom_range(0, 1) == 1;
      MMdREN    = ($urandom_range(0, 3) == 0);
      MMdWEN    = ($urandom_range(0, 5) == 0);
      MMhalt    = ($urandom_range(0, 29) == 0);
      EXmemRead = $urandom_range(0, 1) == 1;
      EXpcSrc   = ($urandom_range(0, 5) == 0);
      EXrd      = 5'($urandom_range(0, 3));
      IDrs      = 5'($urandom_range(0, 3));
      IDrt      = 5'($urandom_range(0, 3));
      #1;
      e = model_out();
      total++;
      if (en_vec !== e || s_en_vec !== e) begin
        bad++; $display("[TB] FAIL rand_en[%0d] got=%b small=%b want=%b", n, en_vec, s_en_vec, e);
      end
      total++;
      if (halt !== m_halt || s_halt !== m_halt) begin
        bad++; $display("[TB] FAIL rand_halt[%0d] got=%b want=%b", n, halt, m_halt);
      end
      total++;
      if (stall_count !== 16'(cap(m_cnt, 65535)) || s_stall_count !== 4'(cap(m_cnt, 15))) begin
        bad++; $display("[TB] FAIL rand_cnt[%0d] got=%0d/%0d want=%0d", n, stall_count, s_stall_count, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_r0_exempt();
    test_dwait();
    test_redirect();
    test_halt();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
